// File: rtl/gray_cnt_ctrl_if.sv
// Command channel for gray_cnt_ctrl.
// Signals:
//   cmd_valid - requester has a command
//   cmd_ready - sequencer can take a command (IDLE only)
//   cmd_op    - 00 CLEAR, 01 LOAD, 10 RUN_UP, 11 RUN_DOWN
//   cmd_data  - LOAD value, binary-coded
//   cmd_steps - RUN step count
// Modports: master (requester side), slave (sequencer side).
interface gray_cnt_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [CNT_WIDTH-1:0]  cmd_steps;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_steps,
    output cmd_ready
  );
endinterface

// File: rtl/gray_cnt_ctrl.sv
// Command-driven sequencer for a Gray counter register.
// Accepts CLEAR / LOAD / RUN_UP / RUN_DOWN over a valid/ready channel, steps the Gray value
// one code per cycle while running (pausing on i_hold), and pulses done/wrap.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - synchronous active-high reset
//   cmd      - command channel (slave side)
//   i_hold   - pause stepping while high (RUN only)
//   gray_out - registered Gray count
//   busy     - high in RUN
//   done     - one-cycle pulse in the cycle after a command completes
//   wrap     - one-cycle pulse when the count has just wrapped
module gray_cnt_ctrl #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  gray_cnt_ctrl_if.slave        cmd,
  input  logic                  i_hold,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_gray;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic                  r_dir_down;
  logic                  r_wrap;

  logic [DATA_WIDTH-1:0] w_bin;
  logic [DATA_WIDTH-1:0] w_bin_next;
  logic [DATA_WIDTH-1:0] w_gray_next;
  logic                  w_wrap_next;

  function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Step in binary and re-encode, so each advance flips exactly one Gray bit.
  always_comb begin
    w_bin       = gray2bin(r_gray);
    w_bin_next  = r_dir_down ? (w_bin - DATA_WIDTH'(1)) : (w_bin + DATA_WIDTH'(1));
    w_gray_next = bin2gray(w_bin_next);
    w_wrap_next = r_dir_down ? (w_bin == '0) : (w_bin == '1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_gray      <= '0;
      r_remaining <= '0;
      r_dir_down  <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
              2'b00: begin
                r_gray  <= '0;
                r_state <= StDone;
              end
              2'b01: begin
                r_gray  <= bin2gray(cmd.cmd_data);
                r_state <= StDone;
              end
              default: begin
                if (cmd.cmd_steps == '0) begin
                  r_state <= StDone;
                end else begin
                  r_remaining <= cmd.cmd_steps;
                  r_dir_down  <= cmd.cmd_op[0];
                  r_state     <= StRun;
                end
              end
            endcase
          end
        end
        StRun: begin
          if (!i_hold) begin
            r_gray      <= w_gray_next;
            r_wrap      <= w_wrap_next;
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            if (r_remaining == CNT_WIDTH'(1)) begin
              r_state <= StDone;
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_ready = (r_state == StIdle);
  assign busy          = (r_state == StRun);
  assign done          = (r_state == StDone);
  assign gray_out      = r_gray;
  assign wrap          = r_wrap;

endmodule

// File: tb/tb_gray_cnt_ctrl.sv
module tb_gray_cnt_ctrl;
  localparam int DW   = 4;
  localparam int CW   = 8;
  localparam int MASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_hold;
  logic [DW-1:0] gray_out;
  logic          busy;
  logic          done;
  logic          wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int m_bin    = 0;  // expected count as a plain binary integer
  int exp_wrap = 0;

  gray_cnt_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_if ();

  gray_cnt_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .cmd      (u_if),
    .i_hold   (i_hold),
    .gray_out (gray_out),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic int g(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic do_cmd(input logic [1:0] op, input int data, input int steps,
                        input int hold_pct, input logic [31:0] hmask,
                        input bit keep_valid, input int kdata);
    int adv;
    int cyc;
    int prev_g;
    bit hold;
    bit is_run;
    check("ready_before", u_if.cmd_ready, 1);
    check("busy_before", busy, 0);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_data  = DW'(data);
    u_if.cmd_steps = CW'(steps);
    i_hold         = 1'($urandom_range(0, 1));
    @(negedge clk);
    // Scramble or replace command fields; they must not matter after accept.
    if (keep_valid) begin
      u_if.cmd_op    = 2'b01;
      u_if.cmd_data  = DW'(kdata);
      u_if.cmd_steps = CW'($urandom);
    end else begin
      u_if.cmd_valid = 1'b0;
      u_if.cmd_op    = 2'($urandom);
      u_if.cmd_data  = DW'($urandom);
      u_if.cmd_steps = CW'($urandom);
    end
    is_run   = op[1] && (steps != 0);
    exp_wrap = 0;
    if (!is_run) begin
      if (op == 2'b00) m_bin = 0;
      else if (op == 2'b01) m_bin = data & MASK;
    end else begin
      adv    = 0;
      cyc    = 0;
      prev_g = g(m_bin);
      while (adv < steps) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        check("run_ready", u_if.cmd_ready, 0);
        check("run_gray", gray_out, g(m_bin));
        check("run_wrap", wrap, exp_wrap);
        if (exp_wrap != 0 || $countones(gray_out ^ DW'(prev_g)) != 0)
          check("run_onebit", $countones(gray_out ^ DW'(prev_g)), 1);
        prev_g = int'(gray_out);
        hold   = (cyc < 32 && hmask[cyc]) || ($urandom_range(0, 99) < hold_pct);
        i_hold = hold;
        @(negedge clk);
        cyc++;
        if (!hold) begin
          if (op[0]) begin
            exp_wrap = (m_bin == 0) ? 1 : 0;
            m_bin    = (m_bin + MASK) & MASK;
          end else begin
            exp_wrap = (m_bin == MASK) ? 1 : 0;
            m_bin    = (m_bin + 1) & MASK;
          end
          adv++;
        end else begin
          exp_wrap = 0;
        end
      end
      check("last_onebit", $countones(gray_out ^ DW'(prev_g)), 1);
    end
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_ready", u_if.cmd_ready, 0);
    check("done_gray", gray_out, g(m_bin));
    check("done_wrap", wrap, exp_wrap);
    i_hold = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_ready", u_if.cmd_ready, 1);
    check("idle_wrap", wrap, 0);
    check("idle_gray", gray_out, g(m_bin));
    if (keep_valid) begin
      // The held LOAD is taken on this first IDLE edge.
      @(negedge clk);
      u_if.cmd_valid = 1'b0;
      m_bin = kdata & MASK;
      check("held_done", done, 1);
      check("held_gray", gray_out, g(m_bin));
      check("held_wrap", wrap, 0);
      @(negedge clk);
      check("held_idle", u_if.cmd_ready, 1);
    end
  endtask

  initial begin
    i_rst          = 1'b1;
    i_hold         = 1'b0;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op    = 2'b00;
    u_if.cmd_data  = '0;
    u_if.cmd_steps = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gray", gray_out, 0);
    check("rst_ready", u_if.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    i_rst = 1'b0;
    m_bin = 0;
    @(negedge clk);

    // Full lap upward with wrap on the final code.
    do_cmd(2'b10, 0, 16, 0, 32'h0, 1'b0, 0);
    check("lap_final", gray_out, 4'b0000);

    do_cmd(2'b01, 5, 0, 0, 32'h0, 1'b0, 0);
    check("load5", gray_out, 4'b0111);
    do_cmd(2'b11, 0, 3, 0, 32'h0, 1'b0, 0);
    check("down3", gray_out, 4'b0011);

    do_cmd(2'b00, 0, 0, 0, 32'h0, 1'b0, 0);
    check("clear", gray_out, 4'b0000);
    // Three held cycles in mid-run.
    do_cmd(2'b10, 0, 4, 0, 32'h0000_000e, 1'b0, 0);
    check("hold_final", gray_out, 4'b0110);

    // Command held valid through RUN and DONE.
    do_cmd(2'b10, 0, 3, 0, 32'h0, 1'b1, 9);
    check("held_final", gray_out, 4'b1101);

    do_cmd(2'b11, 0, 0, 0, 32'h0, 1'b0, 0);
    do_cmd(2'b11, 0, 1, 0, 32'h0, 1'b0, 0);

    // Reset in the middle of RUN_UP N=10.
    do_cmd(2'b00, 0, 0, 0, 32'h0, 1'b0, 0);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = 2'b10;
    u_if.cmd_steps = CW'(10);
    i_hold         = 1'b0;
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_gray", gray_out, g(2));
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    m_bin = 0;
    check("abort_gray", gray_out, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", u_if.cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_wrap", wrap, 0);
    @(negedge clk);
    check("abort_nodone", done, 0);
    check("abort_idle", u_if.cmd_ready, 1);

    // Random command mix with random holds.
    for (int k = 0; k < 40; k++) begin
      logic [1:0] rop;
      int rsteps;
      rop    = 2'($urandom_range(0, 3));
      rsteps = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      do_cmd(rop, int'($urandom_range(0, MASK)), rsteps, 25, 32'h0,
             ($urandom_range(0, 4) == 0), int'($urandom_range(0, MASK)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
